gate_sweep_ctrl: RTL and testbench

Self-checking stimulus sequencer for a small combinational gate under test, such as the two-input behavioural AND.
- On `start`, walks the gate's input vector through all 2^N_IN combinations in ascending order.
- Waits a programmable settle time on each vector, then samples the gate output.
- Compares each sample against a parameterised truth table and counts mismatches.
- Reports pass/fail and the first failing vector.
- Sits beside the gate in bring-up benches and on-chip self-test wrappers, replacing hand-written `#10` stimulus lists.

---
 rtl/gate_sweep_pkg.sv | 20 ++
 rtl/sweep_settle_timer.sv | 40 ++++
 rtl/gate_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep controller.
// Truth tables are indexed by input vector: bit i = output for vector i.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic int nvec(input int n);
        return 1 << n;
    endfunction

    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle down-counter: load arms it for SETTLE wait cycles,
// expire is high while the count has reached zero.
module sweep_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [W-1:0] LOADV = W'(SETTLE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down to zero and stop
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOADV;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive stimulus sequencer and checker for a small gate:
// drives every input vector, samples after settling, scores result.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                     N_IN   = 2,
    parameter int                     SETTLE = 1,
    parameter logic [nvec(N_IN)-1:0]  TRUTH  = TT_AND2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] gut_in,
    input  logic            gut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [N_IN-1:0] ffi_q, ffi_d;
    logic            pass_q, pass_d;
    logic            t_load, t_en, t_expire;

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (t_load),
        .en     (t_en),
        .expire (t_expire)
    );

    // Sweep FSM and scoreboard next-state; abort pre-empts sampling
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ffi_d   = ffi_q;
        pass_d  = pass_q;
        t_load  = 1'b0;
        t_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ffi_d   = '0;
                    pass_d  = 1'b0;
                    t_load  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    t_en = 1'b1;
                    if (t_expire) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (gut_out != TRUTH[idx_q]) begin
                        err_d = err_q + (N_IN+1)'(1);
                        if (!fv_q) begin
                            fv_d  = 1'b1;
                            ffi_d = idx_q;
                        end
                    end
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + N_IN'(1);
                        t_load  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                pass_d  = abort ? 1'b0 : (err_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ffi_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ffi_q   <= ffi_d;
            pass_q  <= pass_d;
        end
    end

    assign gut_in         = idx_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign fail_valid     = fv_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: SETTLE=1 and SETTLE=3
// instances, selectable gate model, abort and reset scenarios.
module tb_gate_sweep_ctrl;

    localparam logic [3:0] TT = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, abort0 = 1'b0;
    logic       start3 = 1'b0, abort3 = 1'b0;
    logic [1:0] gin0, gin3, ffi0, ffi3;
    logic       gout0, gout3;
    logic       busy0, done0, pass0, fv0;
    logic       busy3, done3, pass3, fv3;
    logic [2:0] err0, err3;

    int   mode = 0;
    logic glitch = 1'b0;
    int   sel = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [1:0] gin, ffi;
    logic       busy, done, pass, fv;
    logic [2:0] err;

    typedef struct {
        int err;
        int fv;
        int ffi;
        int dur;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic gmod(input int m, input logic [1:0] v);
        case (m)
            1:       return 1'b0;
            2:       return ~(v[0] & v[1]);
            default: return v[0] & v[1];
        endcase
    endfunction

    assign gout0 = gmod(mode, gin0) ^ glitch;
    assign gout3 = gmod(mode, gin3) ^ glitch;

    gate_sweep_ctrl dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start0),
        .abort          (abort0),
        .gut_in         (gin0),
        .gut_out        (gout0),
        .busy           (busy0),
        .done           (done0),
        .pass           (pass0),
        .err_cnt        (err0),
        .fail_valid     (fv0),
        .first_fail_idx (ffi0)
    );

    gate_sweep_ctrl #(
        .N_IN   (2),
        .SETTLE (3),
        .TRUTH  (4'b1000)
    ) dut3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start3),
        .abort          (abort3),
        .gut_in         (gin3),
        .gut_out        (gout3),
        .busy           (busy3),
        .done           (done3),
        .pass           (pass3),
        .err_cnt        (err3),
        .fail_valid     (fv3),
        .first_fail_idx (ffi3)
    );

    always_comb begin
        gin  = gin0;
        busy = busy0;
        done = done0;
        pass = pass0;
        err  = err0;
        fv   = fv0;
        ffi  = ffi0;
        if (sel == 1) begin
            gin  = gin3;
            busy = busy3;
            done = done3;
            pass = pass3;
            err  = err3;
            fv   = fv3;
            ffi  = ffi3;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic s, input logic a);
        if (sel == 1) begin
            start3 = s;
            abort3 = a;
        end else begin
            start0 = s;
            abort0 = a;
        end
    endtask

    task automatic push_exp(input int m, input int s, input int nv);
        exp_t e;
        e.err = 0;
        e.fv  = 0;
        e.ffi = 0;
        for (int v = 0; v < nv; v++) begin
            if (gmod(m, 2'(v)) !== TT[v]) begin
                if (e.fv == 0) begin
                    e.fv  = 1;
                    e.ffi = v;
                end
                e.err++;
            end
        end
        e.dur = 4 * (s + 1) + 1;
        sb.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gut_in"}, gin0, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_pass"}, pass0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_fv"}, fv0, 0);
        check({tag, "_ffi"}, ffi0, 0);
        check({tag, "_busy3"}, busy3, 0);
    endtask

    // One sweep; abort_at/restart_at are 1-based busy-cycle numbers
    task automatic sweep(input int u, input int m, input bit gl,
                         input int restart_at, input int abort_at);
        int   s;
        int   cyc;
        bit   seen;
        exp_t e;
        sel  = u;
        mode = m;
        s    = (u == 1) ? 3 : 1;
        push_exp(m, s, (abort_at < 0) ? 4 : (abort_at - 1) / (s + 1));
        drv(1'b1, 1'b0);
        step();
        drv(1'b0, 1'b0);
        cyc  = 0;
        seen = 0;
        for (int k = 0; k < 64; k++) begin
            cyc++;
            if (cyc == 1) begin
                check("start_busy", busy, 1);
                check("start_err_clr", err, 0);
                check("start_fv_clr", fv, 0);
            end
            if (cyc <= 4 * (s + 1)) begin
                check("gut_in_seq", gin, (cyc - 1) / (s + 1));
            end
            glitch = gl && ((cyc - 1) % (s + 1) == 0)
                        && (cyc <= 4 * (s + 1));
            drv(cyc == restart_at, cyc == abort_at);
            if (done) begin
                seen = 1;
                break;
            end
            step();
            if (cyc == abort_at) begin
                break;
            end
        end
        drv(1'b0, 1'b0);
        glitch = 1'b0;
        e = sb.pop_front();
        if (abort_at < 0) begin
            check("done_seen", seen, 1);
            check("done_cycle", cyc, e.dur);
            check("err_cnt", err, e.err);
            check("fail_valid", fv, e.fv);
            if (e.fv != 0) begin
                check("first_fail_idx", ffi, e.ffi);
            end
            step();
            check("pass", pass, (e.err == 0) ? 1 : 0);
            check("done_one_cycle", done, 0);
            check("busy_after", busy, 0);
            check("gut_in_hold", gin, 3);
        end else begin
            check("abort_no_done", seen, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_pass", pass, 0);
            check("abort_err", err, e.err);
            check("abort_fv", fv, e.fv);
            check("abort_ffi", ffi, e.ffi);
            step();
            check("abort_done_later", done, 0);
        end
    endtask

    initial begin
        #3;
        check_reset("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        sweep(0, 0, 1'b0, -1, -1);
        sweep(0, 1, 1'b0, -1, -1);
        sweep(0, 2, 1'b0, -1, -1);
        sweep(1, 0, 1'b1, -1, -1);
        sweep(0, 0, 1'b0, 4, -1);
        sweep(0, 2, 1'b0, -1, 6);
        sweep(0, 0, 1'b0, -1, -1);

        sel  = 0;
        mode = 2;
        drv(1'b1, 1'b0);
        step();
        drv(1'b0, 1'b0);
        step();
        step();
        check("pre_rst_err", err0, 1);
        check("pre_rst_busy", busy0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        sweep(0, 0, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
